tank_hit_tracker: RTL and testbench

TANK_HIT_TRACKER -- requirements
Module: tank_hit_tracker

---
 rtl/tank_hit_tracker.sv | 160 ++++++++++++++++
 tb/tb_tank_hit_tracker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_hit_tracker.sv
// tank_hit_tracker: detects opposing-bullet contact with the tank and tracks health and game over.
// Define TANK_HIT_INVULN_EN to add a post-hit invulnerability window with a sprite flash.
module tank_hit_tracker #(
    parameter int TANK_SIZE     = 16,
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_FRAMES = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] tankX,
    input  logic [9:0] tankY,
    input  logic [9:0] bulletX,
    input  logic [9:0] bulletY,
    input  logic [9:0] bulletSx,
    input  logic [9:0] bulletSy,
    input  logic [1:0] bulletOn,
    input  logic       restart,
    output logic       hit_pulse,
    output logic [3:0] health,
    output logic       game_over,
    output logic       flash
);

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        COOLDOWN = 2'd1,
        DEAD     = 2'd2
    } state_t;

    localparam logic [10:0] SIZE_11  = 11'(TANK_SIZE);
    localparam logic [3:0]  HEALTH_4 = 4'(MAX_HEALTH);

    generate
        if (MAX_HEALTH < 1 || MAX_HEALTH > 15 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
            TANK_SIZE < 1 || TANK_SIZE > 1023) begin : g_bad_params
            $error("tank_hit_tracker: parameter out of range");
        end
    endgenerate

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_health, w_health_nxt;
    logic        r_arm, w_arm_nxt;
    logic        r_hit_pulse;
    logic        w_hit;
    logic        w_overlap;

    // Box edges are widened to 11 bits so a box near x=1023 cannot wrap into a false miss.
    logic [10:0] w_tank_x, w_tank_y, w_tank_xe, w_tank_ye;
    logic [10:0] w_bul_x, w_bul_y, w_bul_xe, w_bul_ye;

    assign w_tank_x  = {1'b0, tankX};
    assign w_tank_y  = {1'b0, tankY};
    assign w_bul_x   = {1'b0, bulletX};
    assign w_bul_y   = {1'b0, bulletY};
    assign w_tank_xe = w_tank_x + SIZE_11;
    assign w_tank_ye = w_tank_y + SIZE_11;
    assign w_bul_xe  = w_bul_x + {1'b0, bulletSx};
    assign w_bul_ye  = w_bul_y + {1'b0, bulletSy};

    assign w_overlap = (bulletOn != 2'b00) &&
                       (w_bul_x < w_tank_xe) && (w_bul_xe > w_tank_x) &&
                       (w_bul_y < w_tank_ye) && (w_bul_ye > w_tank_y);

`ifdef TANK_HIT_INVULN_EN
    localparam logic [7:0] CNT_LOAD = 8'(INVULN_FRAMES - 1);
    logic [7:0] r_cnt, w_cnt_nxt;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt  = r_state;
        w_health_nxt = r_health;
        w_arm_nxt    = r_arm;
        w_hit        = 1'b0;
`ifdef TANK_HIT_INVULN_EN
        w_cnt_nxt    = r_cnt;
`endif
        if (!w_overlap) begin
            w_arm_nxt = 1'b1;
        end

        if (restart) begin
            w_state_nxt  = ALIVE;
            w_health_nxt = HEALTH_4;
            w_arm_nxt    = 1'b0;
`ifdef TANK_HIT_INVULN_EN
            w_cnt_nxt    = 8'd0;
`endif
        end else begin
            case (r_state)
                ALIVE: begin
                    if (w_overlap && r_arm) begin
                        w_hit        = 1'b1;
                        w_arm_nxt    = 1'b0;
                        w_health_nxt = (r_health == 4'd0) ? 4'd0 : r_health - 4'd1;
                        if (w_health_nxt == 4'd0) begin
                            w_state_nxt = DEAD;
                        end else begin
`ifdef TANK_HIT_INVULN_EN
                            w_state_nxt = COOLDOWN;
                            w_cnt_nxt   = CNT_LOAD;
`else
                            w_state_nxt = ALIVE;
`endif
                        end
                    end
                end
`ifdef TANK_HIT_INVULN_EN
                COOLDOWN: begin
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = ALIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
`endif
                DEAD: begin
                    w_health_nxt = 4'd0;
                end
                default: begin
                    w_state_nxt = ALIVE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments and reset asynchronously.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ALIVE;
            r_health    <= HEALTH_4;
            r_arm       <= 1'b0;
            r_hit_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_health    <= w_health_nxt;
            r_arm       <= w_arm_nxt;
            r_hit_pulse <= w_hit;
        end
    end

`ifdef TANK_HIT_INVULN_EN
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign flash = (r_state == COOLDOWN) && r_cnt[2];
`else
    assign flash = 1'b0;
`endif

    assign hit_pulse = r_hit_pulse;
    assign health    = r_health;
    assign game_over = (r_state == DEAD);

endmodule

// File: tb/tb_tank_hit_tracker.sv
// Self-checking bench for tank_hit_tracker: a frame-level model compared every frame,
// plus directed vectors with hand-computed expectations (macro-specific ones under TANK_HIT_INVULN_EN).
module tb_tank_hit_tracker;

    localparam int TS   = 16;
    localparam int MAXH = 3;
    localparam int INVF = 30;
`ifdef TANK_HIT_INVULN_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [9:0] tankX, tankY, bulletX, bulletY, bulletSx, bulletSy;
    logic [1:0] bulletOn;
    logic       restart;
    logic       hit_pulse;
    logic [3:0] health;
    logic       game_over;
    logic       flash;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    tank_hit_tracker #(
        .TANK_SIZE    (TS),
        .MAX_HEALTH   (MAXH),
        .INVULN_FRAMES(INVF)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .tankX    (tankX),
        .tankY    (tankY),
        .bulletX  (bulletX),
        .bulletY  (bulletY),
        .bulletSx (bulletSx),
        .bulletSy (bulletSy),
        .bulletOn (bulletOn),
        .restart  (restart),
        .hit_pulse(hit_pulse),
        .health   (health),
        .game_over(game_over),
        .flash    (flash)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: health count, dead flag, re-arm flag and the edge index of the last hit.
    int m_health  = MAXH;
    bit m_dead    = 1'b0;
    bit m_arm     = 1'b0;
    bit m_pulse   = 1'b0;
    int m_edge    = 0;
    int m_last    = -1000;

    function automatic bit model_overlap();
        return (bulletOn != 2'b00) &&
               (int'(bulletX) < int'(tankX) + TS) && (int'(bulletX) + int'(bulletSx) > int'(tankX)) &&
               (int'(bulletY) < int'(tankY) + TS) && (int'(bulletY) + int'(bulletSy) > int'(tankY));
    endfunction

    function automatic bit model_flash();
        int k = m_edge - m_last;
        return INV_EN && !m_dead && (k >= 0) && (k < INVF) && ((((INVF - 1 - k) >> 2) & 1) == 1);
    endfunction

    always @(posedge frame_clk or posedge Reset) begin : model
        int e, h, lh;
        bit ov, hit, arm, dead;
        if (Reset) begin
            m_health <= MAXH;
            m_dead   <= 1'b0;
            m_arm    <= 1'b0;
            m_pulse  <= 1'b0;
            m_edge   <= 0;
            m_last   <= -1000;
        end else begin
            e    = m_edge + 1;
            h    = m_health;
            lh   = m_last;
            arm  = m_arm;
            dead = m_dead;
            hit  = 1'b0;
            ov   = model_overlap();
            if (restart) begin
                h    = MAXH;
                dead = 1'b0;
                arm  = 1'b0;
                lh   = -1000;
            end else begin
                if (ov && arm && !dead && !(INV_EN && (e - lh <= INVF))) begin
                    hit = 1'b1;
                    h   = (h > 0) ? h - 1 : 0;
                    lh  = e;
                    if (h == 0) dead = 1'b1;
                end
                if (!ov) arm = 1'b1;
                else if (hit) arm = 1'b0;
            end
            m_edge   <= e;
            m_health <= h;
            m_last   <= lh;
            m_arm    <= arm;
            m_dead   <= dead;
            m_pulse  <= hit;
        end
    end

    always @(negedge frame_clk) begin
        if (cmp_en) begin
            check("cmp_hit_pulse", 32'(hit_pulse), 32'(m_pulse));
            check("cmp_health",    32'(health),    32'(m_health));
            check("cmp_game_over", 32'(game_over), 32'(m_dead));
            check("cmp_flash",     32'(flash),     32'(model_flash()));
        end
    end

    task automatic frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic place(input int x, input int y, input int on);
        bulletX  = 10'(x);
        bulletY  = 10'(y);
        bulletOn = 2'(on);
    endtask

    task automatic away();
        place(300, 300, 1);
    endtask

    task automatic hit_here();
        place(110, 105, 1);
    endtask

    initial begin
        tankX = 10'd100; tankY = 10'd100;
        bulletSx = 10'd8; bulletSy = 10'd8;
        restart = 1'b0;
        away();
        Reset = 1'b1;
        frames(1);
        cmp_en = 1'b1;
        frames(1);
        check("reset_health",    32'(health),    32'd3);
        check("reset_pulse",     32'(hit_pulse), 32'd0);
        check("reset_game_over", 32'(game_over), 32'd0);
        check("reset_flash",     32'(flash),     32'd0);
        Reset = 1'b0;
        frames(3);

        // One contact held three frames counts once.
        hit_here();
        frames(1);
        check("first_hit_pulse",  32'(hit_pulse), 32'd1);
        check("first_hit_health", 32'(health),    32'd2);
        frames(1);
        check("held_no_pulse_1", 32'(hit_pulse), 32'd0);
        frames(1);
        check("held_no_pulse_2", 32'(hit_pulse), 32'd0);
        check("held_health",     32'(health),    32'd2);
        away();

`ifdef TANK_HIT_INVULN_EN
        frames(7);
        hit_here();
        frames(1);
        check("cooldown_ignore_pulse",  32'(hit_pulse), 32'd0);
        check("cooldown_ignore_health", 32'(health),    32'd2);
        away();
        frames(18);
        hit_here();
        frames(1);
        check("cooldown_edge29", 32'(hit_pulse), 32'd0);
        frames(1);
        check("cooldown_edge30", 32'(hit_pulse), 32'd0);
        frames(1);
        check("rehit_edge31_pulse",  32'(hit_pulse), 32'd1);
        check("rehit_edge31_health", 32'(health),    32'd1);
        away();
        frames(35);
`else
        frames(3);
        hit_here();
        frames(1);
        check("second_hit_pulse",  32'(hit_pulse), 32'd1);
        check("second_hit_health", 32'(health),    32'd1);
        away();
        frames(3);
`endif
        hit_here();
        frames(1);
        check("third_hit_pulse",  32'(hit_pulse), 32'd1);
        check("third_hit_health", 32'(health),    32'd0);
        check("third_hit_dead",   32'(game_over), 32'd1);
        away();
        frames(2);
        hit_here();
        frames(1);
        check("dead_no_pulse",  32'(hit_pulse), 32'd0);
        check("dead_health",    32'(health),    32'd0);
        check("dead_game_over", 32'(game_over), 32'd1);
        away();

        restart = 1'b1;
        frames(1);
        check("restart_health",    32'(health),    32'd3);
        check("restart_game_over", 32'(game_over), 32'd0);
        restart = 1'b0;
        frames(2);

        // Restart wins over a counted hit, and leaves the flag disarmed.
        hit_here();
        restart = 1'b1;
        frames(1);
        check("restart_vs_hit_pulse",  32'(hit_pulse), 32'd0);
        check("restart_vs_hit_health", 32'(health),    32'd3);
        restart = 1'b0;
        frames(1);
        check("restart_disarms", 32'(hit_pulse), 32'd0);
        away();
        frames(2);

        place(116, 105, 1);
        frames(1);
        check("touch_right_edge", 32'(hit_pulse), 32'd0);
        place(92, 105, 1);
        frames(1);
        check("touch_left_edge", 32'(hit_pulse), 32'd0);
        place(100, 100, 0);
        frames(1);
        check("bullet_off", 32'(hit_pulse), 32'd0);
        check("misses_health", 32'(health), 32'd3);
        place(100, 100, 2);
        frames(1);
        check("bullet_on_2_pulse",  32'(hit_pulse), 32'd1);
        check("bullet_on_2_health", 32'(health),    32'd2);
        away();
        frames(1);

        tankX = 10'd630;
        place(1020, 105, 1);
        frames(1);
        check("no_wrap_630", 32'(hit_pulse), 32'd0);
        away();
        frames(32);
        tankX = 10'd1015;
        place(1020, 105, 1);
        frames(1);
        check("edge_11bit_pulse",  32'(hit_pulse), 32'd1);
        check("edge_11bit_health", 32'(health),    32'd1);
        away();
        tankX = 10'd100;
        restart = 1'b1;
        frames(1);
        restart = 1'b0;
        frames(2);

        // Asynchronous reset seventeen frames after a hit (cooldown counter at 12).
        hit_here();
        frames(1);
        check("pre_reset_hit_health", 32'(health), 32'd2);
        away();
        frames(17);
`ifdef TANK_HIT_INVULN_EN
        check("flash_at_cnt12", 32'(flash), 32'd1);
`endif
        #2 Reset = 1'b1;
        #1;
        check("async_reset_health", 32'(health),    32'd3);
        check("async_reset_flash",  32'(flash),     32'd0);
        check("async_reset_pulse",  32'(hit_pulse), 32'd0);
        check("async_reset_go",     32'(game_over), 32'd0);
        #1 Reset = 1'b0;
        frames(2);
        check("post_reset_pulse", 32'(hit_pulse), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
